pe_skew_feeder: RTL and testbench

PE_SKEW_FEEDER -- requirements
Module: pe_skew_feeder

---
 rtl/pe_feeder_pkg.sv | 18 +
 rtl/feeder_lane.sv | 81 ++++++++
 rtl/pe_skew_feeder.sv | 161 ++++++++++++++++
 tb/tb_pe_skew_feeder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg
//   Shared definitions for the skewed systolic-array feeder:
//     - default element width, lane count and per-lane depth
//     - FSM state encoding (IDLE, STREAM, DRAIN)
//   Optional feature macro used by the top: PE_FEEDER_DRAIN_WAIT_EN.
package pe_feeder_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LANES_DEF  = 8;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/feeder_lane.sv
// feeder_lane
//   One output lane of the skew feeder. Compares the shared stream counter
//   against this lane's window [LANE_IDX, LANE_IDX+DEPTH), muxes the matching
//   buffer entry onto its registered outputs and raises its done flag once the
//   window has been passed.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             stream accepted: zero outputs and done
//   step              advance one stream cycle using cnt
//   cnt               shared stream cycle counter
//   ent_act, ent_wgt  this lane's DEPTH buffer entries, entry k at [k*DATA_W +: DATA_W]
//   act, wgt          registered lane data (zero outside the window)
//   done              end-of-stream marker, sticky until clear or reset
module feeder_lane
    import pe_feeder_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LANE_IDX = 0,
    parameter int CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    step,
    input  logic [CNT_W-1:0]        cnt,
    input  logic [DEPTH*DATA_W-1:0] ent_act,
    input  logic [DEPTH*DATA_W-1:0] ent_wgt,
    output logic [DATA_W-1:0]       act,
    output logic [DATA_W-1:0]       wgt,
    output logic                    done
);

    // Counter value at which the window has just been passed.
    localparam logic [CNT_W-1:0] DONE_AT = CNT_W'(LANE_IDX + DEPTH);

    logic [DATA_W-1:0] act_d, act_q;
    logic [DATA_W-1:0] wgt_d, wgt_q;
    logic              done_d, done_q;

    always_comb begin
        act_d  = act_q;
        wgt_d  = wgt_q;
        done_d = done_q;
        if (clear) begin
            act_d  = '0;
            wgt_d  = '0;
            done_d = 1'b0;
        end else if (step) begin
            // Zero unless the counter sits inside this lane's window.
            act_d = '0;
            wgt_d = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (cnt == CNT_W'(LANE_IDX + j)) begin
                    act_d = ent_act[j*DATA_W +: DATA_W];
                    wgt_d = ent_wgt[j*DATA_W +: DATA_W];
                end
            end
            if (cnt == DONE_AT) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= '0;
            wgt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            wgt_q  <= wgt_d;
            done_q <= done_d;
        end
    end

    assign act  = act_q;
    assign wgt  = wgt_q;
    assign done = done_q;

endmodule

// File: rtl/pe_skew_feeder.sv
// pe_skew_feeder
//   Buffers LANES*DEPTH activation/weight pairs and, on start, streams them to
//   a PE array with a one-cycle skew per lane: lane i emits entry i*DEPTH+k in
//   cycle T+1+i+k and raises done[i] in cycle T+1+i+DEPTH.
//   Optional feature macro: PE_FEEDER_DRAIN_WAIT_EN -- when defined, the end of
//   the stream waits in DRAIN for drain_done before returning to IDLE; when
//   undefined, the stream returns straight to IDLE and drain_done is ignored.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    global enable, low freezes everything
//   wr_en, wr_addr        buffer write strobe and entry index (lane*DEPTH + k)
//   wr_act, wr_wgt        data written at wr_addr
//   start                 one-cycle stream request (IDLE only)
//   drain_done            last-column done from the PE cluster
//   activations, weights  skewed lane data, lane i at [i*DATA_W +: DATA_W]
//   done                  per-lane end-of-stream markers
//   busy                  FSM not in IDLE
//   wr_err                one-cycle pulse for a write attempted while busy
//   dbg_state             current FSM state
module pe_skew_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          wr_en,
    input  logic [$clog2(LANES*DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]             wr_act,
    input  logic [DATA_W-1:0]             wr_wgt,
    input  logic                          start,
    input  logic                          drain_done,
    output logic [LANES*DATA_W-1:0]       activations,
    output logic [LANES*DATA_W-1:0]       weights,
    output logic [LANES-1:0]              done,
    output logic                          busy,
    output logic                          wr_err,
    output state_e                        dbg_state
);

    localparam int ENTRIES = LANES * DEPTH;
    localparam int CNT_W   = $clog2(LANES + DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANES + DEPTH - 1);

    state_e            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              wr_err_d, wr_err_q;
    logic              mem_we;
    logic              start_acc;
    logic              step;

    // Buffer has no reset: contents survive reset by design.
    logic [DATA_W-1:0] act_mem_q [ENTRIES];
    logic [DATA_W-1:0] wgt_mem_q [ENTRIES];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_err_d  = wr_err_q;
        mem_we    = 1'b0;
        start_acc = 1'b0;
        step      = 1'b0;
        if (en) begin
            wr_err_d = wr_en && (state_q != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    mem_we = wr_en;
                    if (start) begin
                        start_acc = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    step = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Leave one cycle after the last lane reports done.
                    if (done[LANES-1]) begin
`ifdef PE_FEEDER_DRAIN_WAIT_EN
                        state_d = ST_DRAIN;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
                ST_DRAIN: begin
`ifdef PE_FEEDER_DRAIN_WAIT_EN
                    if (drain_done) begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifndef PE_FEEDER_DRAIN_WAIT_EN
    logic unused_drain_done;
    assign unused_drain_done = drain_done;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            act_mem_q[wr_addr] <= wr_act;
            wgt_mem_q[wr_addr] <= wr_wgt;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DEPTH*DATA_W-1:0] ent_act;
        logic [DEPTH*DATA_W-1:0] ent_wgt;

        for (genvar j = 0; j < DEPTH; j++) begin : g_ent
            assign ent_act[j*DATA_W +: DATA_W] = act_mem_q[i*DEPTH + j];
            assign ent_wgt[j*DATA_W +: DATA_W] = wgt_mem_q[i*DEPTH + j];
        end

        feeder_lane #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .LANE_IDX (i),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (start_acc),
            .step    (step),
            .cnt     (cnt_q),
            .ent_act (ent_act),
            .ent_wgt (ent_wgt),
            .act     (activations[i*DATA_W +: DATA_W]),
            .wgt     (weights[i*DATA_W +: DATA_W]),
            .done    (done[i])
        );
    end

    assign busy      = (state_q != ST_IDLE);
    assign wr_err    = wr_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pe_skew_feeder.sv
// tb_pe_skew_feeder
//   Directed bench for pe_skew_feeder at default parameters. Inputs are driven
//   and outputs sampled on the falling edge; "cycle T+n" is the falling edge
//   after the n-th rising edge following the edge that accepted start.
module tb_pe_skew_feeder;
    import pe_feeder_pkg::*;

    localparam int DW = 16;
    localparam int NL = 8;
    localparam int ND = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DW-1:0]     wr_act;
    logic [DW-1:0]     wr_wgt;
    logic              start;
    logic              drain_done;
    logic [NL*DW-1:0]  activations;
    logic [NL*DW-1:0]  weights;
    logic [NL-1:0]     done;
    logic              busy;
    logic              wr_err;
    state_e            dbg_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pe_skew_feeder #(.DATA_W(DW), .LANES(NL), .DEPTH(ND)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_act      (wr_act),
        .wr_wgt      (wr_wgt),
        .start       (start),
        .drain_done  (drain_done),
        .activations (activations),
        .weights     (weights),
        .done        (done),
        .busy        (busy),
        .wr_err      (wr_err),
        .dbg_state   (dbg_state)
    );

    typedef struct {
        int            cyc;
        int            lane;
        logic [DW-1:0] act;
        logic [DW-1:0] wgt;
        logic [NL-1:0] dn;
        logic          bsy;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane_act(input int l);
        return activations[l*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] lane_wgt(input int l);
        return weights[l*DW +: DW];
    endfunction

    task automatic write_entry(input int addr, input logic [DW-1:0] a, input logic [DW-1:0] w);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_act  = a;
        wr_wgt  = w;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Leaves the bench at cycle T (falling edge after the accepting edge).
    task automatic start_stream();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_act     = '0;
        wr_wgt     = '0;
        start      = 1'b0;
        drain_done = 1'b0;

        vecs[0]  = '{0,  0, 16'h0000, 16'h0000, 8'h00, 1'b1};
        vecs[1]  = '{1,  0, 16'h0001, 16'h0100, 8'h00, 1'b1};
        vecs[2]  = '{1,  1, 16'h0000, 16'h0000, 8'h00, 1'b1};
        vecs[3]  = '{2,  1, 16'h0005, 16'h0104, 8'h00, 1'b1};
        vecs[4]  = '{4,  3, 16'h000D, 16'h010C, 8'h00, 1'b1};
        vecs[5]  = '{5,  3, 16'h000E, 16'h010D, 8'h01, 1'b1};
        vecs[6]  = '{5,  0, 16'h0000, 16'h0000, 8'h01, 1'b1};
        vecs[7]  = '{6,  3, 16'h000F, 16'h010E, 8'h03, 1'b1};
        vecs[8]  = '{7,  3, 16'h0010, 16'h010F, 8'h07, 1'b1};
        vecs[9]  = '{8,  3, 16'h0000, 16'h0000, 8'h0F, 1'b1};
        vecs[10] = '{8,  7, 16'h001D, 16'h011C, 8'h0F, 1'b1};
        vecs[11] = '{11, 7, 16'h0020, 16'h011F, 8'h7F, 1'b1};
        vecs[12] = '{12, 7, 16'h0000, 16'h0000, 8'hFF, 1'b1};
`ifdef PE_FEEDER_DRAIN_WAIT_EN
        vecs[13] = '{13, 0, 16'h0000, 16'h0000, 8'hFF, 1'b1};
`else
        vecs[13] = '{13, 0, 16'h0000, 16'h0000, 8'hFF, 1'b0};
`endif

        // Reset state
        #1;
        check("rst_act",    activations[31:0], 32'd0);
        check("rst_wgt",    weights[31:0],     32'd0);
        check("rst_done",   {24'd0, done},     32'd0);
        check("rst_busy",   {31'd0, busy},     32'd0);
        check("rst_wr_err", {31'd0, wr_err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < NL*ND; n++) begin
            write_entry(n, DW'(n + 1), DW'(16'h0100 + n));
        end

        // Main table-driven stream
        start_stream();
        for (int c = 0; c <= 13; c++) begin
            for (int v = 0; v < 14; v++) begin
                if (vecs[v].cyc == c) begin
                    check($sformatf("vec%0d_act", v),  {16'd0, lane_act(vecs[v].lane)}, {16'd0, vecs[v].act});
                    check($sformatf("vec%0d_wgt", v),  {16'd0, lane_wgt(vecs[v].lane)}, {16'd0, vecs[v].wgt});
                    check($sformatf("vec%0d_done", v), {24'd0, done},                   {24'd0, vecs[v].dn});
                    check($sformatf("vec%0d_busy", v), {31'd0, busy},                   {31'd0, vecs[v].bsy});
                end
            end
            if (c < 13) @(negedge clk);
        end

`ifdef PE_FEEDER_DRAIN_WAIT_EN
        // Drain hold: wait for drain_done
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("drain_busy", {31'd0, busy},   32'd1);
            check("drain_done", {24'd0, done},   32'hFF);
            check("drain_act",  activations[31:0], 32'd0);
        end
        drain_done = 1'b1;
        @(negedge clk);
        drain_done = 1'b0;
        check("drain_exit_busy", {31'd0, busy}, 32'd0);
`endif
        wait_idle("idle_after_table");

        // Write while busy, plus a start that must be ignored
        start_stream();
        step_n(3);
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_act  = 16'hFFFF;
        wr_wgt  = 16'hFFFF;
        start   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        start   = 1'b0;
        check("wr_err_pulse", {31'd0, wr_err}, 32'd1);
        check("busy_lane0_c4", {16'd0, lane_act(0)}, 32'h4);
        @(negedge clk);
        check("wr_err_clear", {31'd0, wr_err}, 32'd0);
        check("ign_start_lane3_c5", {16'd0, lane_act(3)}, 32'hE);
        step_n(7);
        check("ign_start_done_c12", {24'd0, done}, 32'hFF);
        drain_done = 1'b1;
        wait_idle("idle_after_wr_err");
        drain_done = 1'b0;
        start_stream();
        @(negedge clk);
        check("entry0_kept", {16'd0, lane_act(0)}, 32'h1);
        drain_done = 1'b1;
        wait_idle("idle_after_entry0");
        drain_done = 1'b0;

        // Stall for three cycles at T+5
        start_stream();
        step_n(5);
        check("stall_c5", {16'd0, lane_act(3)}, 32'hE);
        en = 1'b0;
        for (int c = 6; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("stall_frozen_c%0d", c), {16'd0, lane_act(3)}, 32'hE);
            check($sformatf("stall_done_c%0d", c),   {24'd0, done},        32'h01);
        end
        en = 1'b1;
        @(negedge clk);
        check("stall_resume_c9",  {16'd0, lane_act(3)}, 32'hF);
        @(negedge clk);
        check("stall_resume_c10", {16'd0, lane_act(3)}, 32'h10);
        step_n(4);
        check("stall_done_c14", {24'd0, done}, 32'h7F);
        @(negedge clk);
        check("stall_done_c15", {24'd0, done}, 32'hFF);
        drain_done = 1'b1;
        wait_idle("idle_after_stall");
        drain_done = 1'b0;

        // Reset mid-stream at T+6
        start_stream();
        step_n(6);
        rst_n = 1'b0;
        #1;
        check("midrst_act",  activations[31:0],   32'd0);
        check("midrst_act7", {16'd0, lane_act(7)}, 32'd0);
        check("midrst_done", {24'd0, done},       32'd0);
        check("midrst_busy", {31'd0, busy},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        start_stream();
        @(negedge clk);
        check("replay_lane0_c1", {16'd0, lane_act(0)}, 32'h1);
        step_n(3);
        check("replay_lane3_c4", {16'd0, lane_act(3)}, 32'hD);
        check("replay_wgt3_c4",  {16'd0, lane_wgt(3)}, 32'h10C);
        drain_done = 1'b1;
        wait_idle("idle_after_replay");
        drain_done = 1'b0;

        // Write coinciding with start: the stream reads the new value
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_act  = 16'h0AAA;
        wr_wgt  = 16'h0BBB;
        start   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        start   = 1'b0;
        step_n(2);
        check("wr_start_act", {16'd0, lane_act(0)}, 32'hAAA);
        check("wr_start_wgt", {16'd0, lane_wgt(0)}, 32'hBBB);
        drain_done = 1'b1;
        wait_idle("idle_final");
        drain_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
